// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg
//   Shared definitions for the pipelined approximate multiplier.
//   - DEF_W / ZW    : default operand width and its full product width.
//   - MAX_W/MAX_ZW  : largest operand/product width the S1 payload record holds.
//   - MAX_TAG_W     : largest sideband tag width the S1 payload record holds.
//   - s1_payload_t  : record registered by stage S1 (hi, low_sum, exact, bias, tag).
//   - masked_low_sum: behavioural form of the truncated low-row sum.
// Ports: none (package).
package approx_mult_pkg;

  localparam int DEF_W     = 8;
  localparam int ZW        = 2 * DEF_W;
  localparam int MAX_W     = 32;
  localparam int MAX_ZW    = 2 * MAX_W;
  localparam int MAX_TAG_W = 32;

  // Fields are sized for the largest supported configuration; instances
  // zero-extend into them and truncate back out, so unused upper bits are
  // constant and disappear in synthesis.
  typedef struct packed {
    logic [MAX_ZW-1:0]    hi;       // exact x_hi*y, already weighted by 2^K
    logic [MAX_ZW-1:0]    low_sum;  // low-row sum, truncated or not by mode
    logic                 exact;    // beat requested the exact product
    logic                 bias;     // beat qualifies for rounding bias
    logic [MAX_TAG_W-1:0] tag;
  } s1_payload_t;

  // Sum of the k low partial-product rows of x*y with every bit of weight
  // below 2^t cleared in each row.
  function automatic logic [MAX_ZW-1:0] masked_low_sum(
    input logic [MAX_W-1:0] x,
    input logic [MAX_W-1:0] y,
    input int               k,
    input int               t
  );
    logic [MAX_ZW-1:0] acc;
    logic [MAX_ZW-1:0] row;
    acc = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < k && x[i]) begin
        row = MAX_ZW'(y) << i;
        for (int b = 0; b < MAX_ZW; b++) begin
          if (b < t) row[b] = 1'b0;
        end
        acc = acc + row;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/approx_lowrows.sv
// approx_lowrows
//   Combinational generator of the K low partial-product rows of x*y.
//   Ports:
//     x, y       [W-1:0]  : unsigned operands
//     low_approx [2W-1:0] : sum of rows 0..K-1, each with weights < 2^T cleared
//     low_exact  [2W-1:0] : x[K-1:0]*y, the untruncated low-row sum
module approx_lowrows
  import approx_mult_pkg::*;
#(
  parameter int W = 8,
  parameter int K = 4,
  parameter int T = 8
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] low_approx,
  output logic [2*W-1:0] low_exact
);

  localparam int PROD_W = 2 * W;
  // Ones in bits [K-1:0]; the W+1 bit intermediate keeps K == W well defined.
  localparam logic [W-1:0] LO_MASK = W'(((W+1)'(1) << K) - (W+1)'(1));

  logic [PROD_W-1:0] keep_mask;
  logic [PROD_W-1:0] acc [0:K];

  genvar gi;

  // Columns at or above T survive truncation.
  for (gi = 0; gi < PROD_W; gi++) begin : g_mask
    assign keep_mask[gi] = (gi >= T);
  end

  assign acc[0] = '0;

  for (gi = 0; gi < K; gi++) begin : g_row
    logic [PROD_W-1:0] row;
    assign row        = x[gi] ? (PROD_W'(y) << gi) : '0;
    assign acc[gi+1]  = acc[gi] + (row & keep_mask);
  end

  assign low_approx = acc[K];
  assign low_exact  = PROD_W'(x & LO_MASK) * PROD_W'(y);

endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe
//   Two-stage valid/ready pipelined W x W unsigned multiplier with a runtime
//   exact/approximate mode and a sideband tag.
//   S1 registers hi = x_hi*y<<K and the (truncated or full) low-row sum;
//   S2 registers their sum into out_z.
//   Ports:
//     clk, rst                 : clock (rising edge), async active-high reset
//     in_valid/in_ready        : operand handshake
//     in_x, in_y [W-1:0]       : operands
//     in_exact                 : 1 = exact product, 0 = approximate
//     in_tag [TAG_W-1:0]       : sideband returned with the result
//     out_valid/out_ready      : result handshake
//     out_z [2W-1:0], out_tag  : product and its tag
//   Build option: define APPROX_MULT_BIAS_EN to add 2^(T-1) to qualifying
//   approximate results, offsetting the mean truncation error.
//   Supported range: W <= MAX_W, TAG_W <= MAX_TAG_W (see approx_mult_pkg).
module approx_mult_pipe #(
  parameter int W     = 8,
  parameter int K     = 4,
  parameter int T     = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic             in_exact,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_z,
  output logic [TAG_W-1:0] out_tag
);

  import approx_mult_pkg::*;

  localparam int PROD_W = 2 * W;
  localparam logic [W-1:0] LO_MASK = W'(((W+1)'(1) << K) - (W+1)'(1));
  localparam int BIAS_SH = (T >= 1) ? (T - 1) : 0;
  localparam logic [MAX_ZW-1:0] BIAS_VAL = (T >= 1) ? (MAX_ZW'(1) << BIAS_SH) : '0;

  logic                s1_valid_reg;
  s1_payload_t         s1_reg;
  s1_payload_t         s1_next;
  logic                out_valid_reg;
  logic [PROD_W-1:0]   out_z_reg;
  logic [TAG_W-1:0]    out_tag_reg;

  logic                s2_adv;
  logic                s1_adv;
  logic [PROD_W-1:0]   hi_prod;
  logic [PROD_W-1:0]   low_approx;
  logic [PROD_W-1:0]   low_exact;
  logic                bias_cond;
  logic [MAX_ZW-1:0]   bias_add;

  // Readiness depends only on registered state and out_ready.
  assign s2_adv   = ~out_valid_reg | out_ready;
  assign s1_adv   = ~s1_valid_reg | s2_adv;
  assign in_ready = s1_adv;

  // Clearing the low K bits of x leaves the exact high part already at weight 2^K.
  assign hi_prod = PROD_W'(in_x & ~LO_MASK) * PROD_W'(in_y);

  approx_lowrows #(
    .W (W),
    .K (K),
    .T (T)
  ) u_lowrows (
    .x          (in_x),
    .y          (in_y),
    .low_approx (low_approx),
    .low_exact  (low_exact)
  );

`ifdef APPROX_MULT_BIAS_EN
  // Bias only when truncation can actually have dropped something.
  assign bias_cond = ~in_exact & (T >= 1) & ((in_x & LO_MASK) != '0) & (in_y != '0);
`else
  assign bias_cond = 1'b0;
`endif

  always_comb begin
    s1_next         = '0;
    s1_next.hi      = MAX_ZW'(hi_prod);
    s1_next.low_sum = MAX_ZW'(in_exact ? low_exact : low_approx);
    s1_next.exact   = in_exact;
    s1_next.bias    = bias_cond;
    s1_next.tag     = MAX_TAG_W'(in_tag);
  end

  assign bias_add = (s1_reg.bias & ~s1_reg.exact) ? BIAS_VAL : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_reg        <= '0;
      out_valid_reg <= 1'b0;
      out_z_reg     <= '0;
      out_tag_reg   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_reg <= in_valid;
        if (in_valid) s1_reg <= s1_next;
      end
      if (s2_adv) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          // Truncating to PROD_W drops any carry produced by the bias.
          out_z_reg   <= PROD_W'(s1_reg.hi + s1_reg.low_sum + bias_add);
          out_tag_reg <= TAG_W'(s1_reg.tag);
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_z     = out_z_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe
//   Self-checking bench for approx_mult_pipe (W=8, K=4, T=8, TAG_W=4).
//   Directed vector table, stream/stall/reset sequences and a randomized
//   run, all checked through an in-order scoreboard fed from an
//   independent arithmetic model. Honors APPROX_MULT_BIAS_EN.
module tb_approx_mult_pipe;

  localparam int W     = 8;
  localparam int K     = 4;
  localparam int T     = 8;
  localparam int TAG_W = 4;

`ifdef APPROX_MULT_BIAS_EN
  localparam logic [15:0] BIAS = 16'h0080;
`else
  localparam logic [15:0] BIAS = 16'h0000;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_x = '0;
  logic [W-1:0]     in_y = '0;
  logic             in_exact = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [2*W-1:0]   out_z;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  approx_mult_pipe #(
    .W     (W),
    .K     (K),
    .T     (T),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_exact  (in_exact),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [15:0] z;
    logic [3:0]  tag;
    logic [15:0] exact_z;
    logic        approx;
  } exp_t;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        ex;
    logic [15:0] z_base;   // result without bias
    logic        biased;   // bias applies when enabled
  } vec_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  logic last_in_xfer = 1'b0;
  logic log_en = 1'b0;
  logic ov_log[$];

  // Reference: hi part by shifting, low rows truncated by shifting right then left.
  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic ex);
    int unsigned xi;
    int unsigned yi;
    int unsigned z;
    int unsigned row;
    xi = x;
    yi = y;
    if (ex) return 16'(xi * yi);
    z = ((xi >> K) * yi) << K;
    for (int i = 0; i < K; i++) begin
      if (x[i]) begin
        row = yi << i;
        z = z + ((row >> T) << T);
      end
    end
`ifdef APPROX_MULT_BIAS_EN
    if (T >= 1 && (xi % (1 << K)) != 0 && yi != 0) z = z + (1 << (T - 1));
`endif
    return 16'(z);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Sampled at the falling edge: what is seen here is what transfers at the next rising edge.
  task automatic monitor_step();
    exp_t e;
    last_in_xfer = 1'b0;
    if (rst) return;
    if (log_en) ov_log.push_back(out_valid);
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected got z=%0h tag=%0h want none", out_z, out_tag);
      end else begin
        e = sb_q.pop_front();
        chk("sb_z", 32'(out_z), 32'(e.z));
        chk("sb_tag", 32'(out_tag), 32'(e.tag));
`ifndef APPROX_MULT_BIAS_EN
        if (e.approx) chk("approx_le_exact", 32'(out_z <= e.exact_z), 32'd1);
`endif
      end
    end
    if (in_valid && in_ready) begin
      e.z       = model(in_x, in_y, in_exact);
      e.tag     = in_tag;
      e.exact_z = 16'(in_x) * 16'(in_y);
      e.approx  = ~in_exact;
      sb_q.push_back(e);
      last_in_xfer = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor_step();
    @(posedge clk);
    #1;
  endtask

  // Offer a beat and hold it until accepted; leaves in_valid high.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic ex, input logic [3:0] tag);
    int n;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_exact = ex;
    in_tag   = tag;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_in_xfer && n < 1000);
    if (!last_in_xfer) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  vec_t vecs[10];
  logic [15:0] want;
  logic [15:0] held_z;
  int nacc;
  int sent;
  int cyc;
  logic [7:0] bx [3];
  logic [7:0] by [3];

  initial begin
    vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFA10, 1'b1};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, 16'hFE01, 1'b0};
    vecs[2] = '{8'h10, 8'h03, 1'b0, 16'h0030, 1'b0};
    vecs[3] = '{8'h0F, 8'h0F, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{8'h0F, 8'h0F, 1'b1, 16'h00E1, 1'b0};
    vecs[5] = '{8'h00, 8'hAB, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{8'hFF, 8'h00, 1'b0, 16'h0000, 1'b0};
    vecs[7] = '{8'hF0, 8'hFF, 1'b0, 16'hEF10, 1'b0};
    vecs[8] = '{8'h81, 8'h80, 1'b0, 16'h4000, 1'b1};
    vecs[9] = '{8'h08, 8'hFF, 1'b0, 16'h0700, 1'b1};

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_z", 32'(out_z), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table, one beat at a time, latency checked
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      want = vecs[i].z_base + (vecs[i].biased ? BIAS : 16'h0000);
      send(vecs[i].x, vecs[i].y, vecs[i].ex, 4'(i));
      in_valid = 1'b0;
      chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
      tick();
      chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
      chk("vec_z", 32'(out_z), 32'(want));
      chk("vec_tag", 32'(out_tag), 32'(i));
      $display("vec %0d x=%h y=%h exact=%0d -> z=%h tag=%0d", i, vecs[i].x, vecs[i].y, vecs[i].ex, out_z, out_tag);
      tick();
    end

    // Back-to-back stream of 16 beats, mode alternating per beat
    ov_log.delete();
    log_en = 1'b1;
    for (int t = 0; t < 16; t++) send(8'($urandom), 8'($urandom), t[0], 4'(t));
    in_valid = 1'b0;
    repeat (4) tick();
    log_en = 1'b0;
    chk("stream_log_len", 32'(ov_log.size()), 32'd20);
    for (int i = 0; i < ov_log.size(); i++)
      chk("stream_out_valid", 32'(ov_log[i]), 32'((i >= 2 && i < 18) ? 1 : 0));
    drain();

    // Stall: consumer blocked for 5 cycles while 3 beats are offered
    bx[0] = 8'hFF; by[0] = 8'hFF;
    bx[1] = 8'h3C; by[1] = 8'hA5;
    bx[2] = 8'h07; by[2] = 8'h99;
    out_ready = 1'b0;
    nacc = 0;
    in_valid = 1'b1; in_x = bx[0]; in_y = by[0]; in_exact = 1'b0; in_tag = 4'd1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (last_in_xfer) begin
        nacc++;
        if (nacc < 3) begin
          in_x = bx[nacc]; in_y = by[nacc]; in_tag = 4'(nacc + 1);
        end
      end
      if (c == 1) held_z = out_z;
      if (c > 1) chk("stall_z_stable", 32'(out_z), 32'(held_z));
    end
    chk("stall_accepted", 32'(nacc), 32'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_z_value", 32'(out_z), 32'(model(bx[0], by[0], 1'b0)));
    out_ready = 1'b1;
    cyc = 0;
    while (nacc < 3 && cyc < 100) begin
      tick();
      cyc++;
      if (last_in_xfer) nacc++;
    end
    chk("stall_third_accepted", 32'(nacc), 32'd3);
    drain();

    // Reset with two beats in flight
    send(8'h12, 8'h34, 1'b0, 4'd5);
    send(8'h56, 8'h78, 1'b1, 4'd6);
    in_valid = 1'b0;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_z", 32'(out_z), 32'd0);
    chk("async_rst_out_tag", 32'(out_tag), 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    end

    // Randomized beats with random backpressure and idle gaps
    in_valid = 1'b0;
    sent = 0;
    cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      if (!in_valid || last_in_xfer) begin
        if ($urandom_range(0, 7) == 0) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_x     = 8'($urandom);
          in_y     = 8'($urandom);
          in_exact = 1'($urandom_range(0, 1));
          in_tag   = 4'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
      if (last_in_xfer) sent++;
    end
    chk("random_beats_sent", 32'(sent), 32'd10000);
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
